// File: rtl/lut_pkg.sv
// -----------------------------------------------------------------------------
// lut_pkg
// Shared types and constants for the instruction-LUT runtime loader.
//   lut_wr_state_t : loader FSM state encoding
//   BYTE_W         : width of one stream byte
//   DEF_ADDR_W     : default table address width
//   DEF_DATA_W     : default table entry width
// Optional feature macro: LUT_WRITER_CHECKSUM_EN (adds the CHECK state).
// -----------------------------------------------------------------------------
package lut_pkg;

   localparam int BYTE_W     = 8;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
`ifdef LUT_WRITER_CHECKSUM_EN
      ST_CHECK = 3'd3,
`endif
      ST_DONE  = 3'd4
   } lut_wr_state_t;

endpackage

// File: rtl/lut_ram.sv
// -----------------------------------------------------------------------------
// lut_ram
// Table storage for the instruction LUT: 2**ADDR_W entries of DATA_W bits,
// one synchronous write port and one asynchronous (combinational) read port.
// Ports:
//   clk   in  write clock
//   we    in  write enable
//   waddr in  write address
//   wdata in  write data
//   raddr in  read address
//   rdata out table[raddr], zero latency
// -----------------------------------------------------------------------------
module lut_ram
   import lut_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // NOTE: the array has no reset branch on purpose: programmed entries must
   // survive rst_n, and a resettable array cannot map onto a RAM macro.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // A read of the address being written returns the old value until the edge.
   assign rdata = mem[raddr];

endmodule

// File: rtl/lut_writer.sv
// -----------------------------------------------------------------------------
// lut_writer
// Runtime loader for the instruction LUT. Accepts a byte stream over a
// valid/ready handshake, assembles little-endian entries and writes them into
// the table held by lut_ram. The combinational read port stays available to
// the PC-driven lookup in every state.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load_start           start a session (sampled only in IDLE)
//   load_base/load_count first address / entry count, captured with load_start
//   byte_valid/byte_data stream input
//   byte_ready           byte accepted this cycle when valid
//   busy                 session active
//   done                 one-cycle end-of-session pulse
//   err                  sticky error, cleared by the next accepted start
//   lut_addr/lut_out     combinational table read
// Optional feature macro: LUT_WRITER_CHECKSUM_EN -- after the last entry a
// DATA_W checksum (XOR of all written entries) is received and compared.
// -----------------------------------------------------------------------------
module lut_writer
   import lut_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W:0]   load_count,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic              byte_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [ADDR_W-1:0] lut_addr,
   output logic [DATA_W-1:0] lut_out
);

   localparam int               BYTES      = DATA_W / BYTE_W;
   localparam int               IDX_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BYTES - 1);
   localparam logic [ADDR_W:0]  FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]  ONE_LEFT   = {{ADDR_W{1'b0}}, 1'b1};

   lut_wr_state_t     state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [IDX_W-1:0]  byte_idx;
   logic [DATA_W-1:0] entry;
   logic [DATA_W-1:0] merged;
   logic              xfer;
   logic              last_byte;
   logic              wr_en;
`ifdef LUT_WRITER_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   assign xfer      = byte_valid && byte_ready;
   assign last_byte = (byte_idx == LAST_IDX);
   assign wr_en     = (state == ST_WRITE);

   // Entry value including the byte on the bus; stored in RECV, compared in CHECK.
   // NOTE: default assignment first so every path assigns merged and no latch is inferred.
   always_comb begin
      merged = entry;
      merged[byte_idx*BYTE_W +: BYTE_W] = byte_data;
   end

   // Outputs are registered: each transition also sets the outputs of the
   // state it enters, so byte_ready/busy/done never glitch.
   // NOTE: all state here uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         addr       <= '0;
         remaining  <= '0;
         byte_idx   <= '0;
         entry      <= '0;
         byte_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef LUT_WRITER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  busy     <= 1'b1;
                  byte_idx <= '0;
                  if (load_count > FULL_COUNT) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else if (load_count == '0) begin
                     err <= 1'b0;
`ifdef LUT_WRITER_CHECKSUM_EN
                     csum       <= '0;
                     byte_ready <= 1'b1;
                     state      <= ST_CHECK;
`else
                     done  <= 1'b1;
                     state <= ST_DONE;
`endif
                  end else begin
                     addr       <= load_base;
                     remaining  <= load_count;
                     err        <= 1'b0;
                     byte_ready <= 1'b1;
                     state      <= ST_RECV;
`ifdef LUT_WRITER_CHECKSUM_EN
                     csum       <= '0;
`endif
                  end
               end
            end

            ST_RECV: begin
               if (xfer) begin
                  entry <= merged;
                  if (last_byte) begin
                     byte_idx   <= '0;
                     byte_ready <= 1'b0;
                     state      <= ST_WRITE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end

            // lut_ram commits entry at addr on the edge that leaves this state.
            ST_WRITE: begin
               addr      <= addr + 1'b1;
               remaining <= remaining - 1'b1;
`ifdef LUT_WRITER_CHECKSUM_EN
               csum      <= csum ^ entry;
`endif
               byte_ready <= 1'b1;
               if (remaining == ONE_LEFT) begin
`ifdef LUT_WRITER_CHECKSUM_EN
                  state <= ST_CHECK;
`else
                  byte_ready <= 1'b0;
                  done       <= 1'b1;
                  state      <= ST_DONE;
`endif
               end else begin
                  state <= ST_RECV;
               end
            end

`ifdef LUT_WRITER_CHECKSUM_EN
            ST_CHECK: begin
               if (xfer) begin
                  if (last_byte) begin
                     byte_idx   <= '0;
                     byte_ready <= 1'b0;
                     done       <= 1'b1;
                     state      <= ST_DONE;
                     if (merged != csum) begin
                        err <= 1'b1;
                     end
                  end else begin
                     entry    <= merged;
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
`endif

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               byte_ready <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

   lut_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (addr),
      .wdata (entry),
      .raddr (lut_addr),
      .rdata (lut_out)
   );

endmodule

// File: tb/tb_lut_writer.sv
// -----------------------------------------------------------------------------
// tb_lut_writer
// Self-checking bench for lut_writer (ADDR_W=8, DATA_W=16). The table model is
// an array indexed by (base + i) mod 256 holding {byte[2i+1], byte[2i]}.
// Build with LUT_WRITER_CHECKSUM_EN to exercise the checksum phase.
// -----------------------------------------------------------------------------
module tb_lut_writer;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      logic [7:0]  base;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [15:0] exp_word;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        load_start;
   logic [7:0]  load_base;
   logic [8:0]  load_count;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  lut_addr;
   logic [15:0] lut_out;

   int checks = 0;
   int errors = 0;
   int done_count = 0;
   int acc_count = 0;
   bit pulse_en = 0;

   logic [15:0] ref_mem [256];
   bit          known   [256];

   lut_writer #(
      .ADDR_W (8),
      .DATA_W (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .load_base  (load_base),
      .load_count (load_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .lut_addr   (lut_addr),
      .lut_out    (lut_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Event counters observed mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (done === 1'b1) done_count++;
      if (byte_valid === 1'b1 && byte_ready === 1'b1) acc_count++;
   end

   // Pulses load_start with junk parameters while a session is in progress.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (pulse_en) begin
            load_start = ($urandom_range(0, 2) == 0);
            load_base  = 8'($urandom);
            load_count = 9'($urandom_range(1, 300));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // All tasks enter and leave at posedge+1.
   task automatic start(input logic [7:0] base, input logic [8:0] count);
      load_base  = base;
      load_count = count;
      load_start = 1'b1;
      @(posedge clk);
      #1;
      load_start = 1'b0;
   endtask

   task automatic send_stream(input byte_q_t bytes, input bit rand_valid);
      int idx;
      int cyc;
      idx = 0;
      cyc = 0;
      while (idx < bytes.size() && cyc < 2000) begin
         byte_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         byte_data  = byte_valid ? bytes[idx] : 8'($urandom);
         @(negedge clk);
         if (byte_valid && byte_ready) idx++;
         @(posedge clk);
         #1;
         cyc++;
      end
      byte_valid = 1'b0;
      check("stream_complete", 32'(idx), 32'(bytes.size()));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("idle_reached", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic read_lut(input logic [7:0] a, output logic [15:0] v);
      lut_addr = a;
      #1;
      v = lut_out;
   endtask

   task automatic run_session(input logic [7:0] base, input int count, input byte_q_t data,
                              input bit rand_valid, input bit pulse);
      byte_q_t     stream;
      logic [15:0] word;
      logic [15:0] sum;
      int          d0;
      int          a0;
      stream = data;
      sum    = '0;
      for (int i = 0; i < count; i++) begin
         word = {data[2*i+1], data[2*i]};
         ref_mem[8'(base + 8'(i))] = word;
         known[8'(base + 8'(i))]   = 1'b1;
         sum = sum ^ word;
      end
`ifdef LUT_WRITER_CHECKSUM_EN
      stream.push_back(sum[7:0]);
      stream.push_back(sum[15:8]);
`endif
      d0 = done_count;
      a0 = acc_count;
      start(base, 9'(count));
      pulse_en = pulse;
      send_stream(stream, rand_valid);
      pulse_en   = 1'b0;
      load_start = 1'b0;
      wait_idle();
      check("bytes_accepted", 32'(acc_count - a0), 32'(stream.size()));
      check("done_pulses", 32'(done_count - d0), 32'd1);
      check("err_clear", 32'(err), 32'd0);
   endtask

   vec_t        vecs [5];
   logic [15:0] v;
   int          d0;
   int          a0;

   initial begin
      vecs[0] = '{8'h20, 8'hCD, 8'hAB, 16'hABCD};
      vecs[1] = '{8'h21, 8'h00, 8'h00, 16'h0000};
      vecs[2] = '{8'h22, 8'hFF, 8'hFF, 16'hFFFF};
      vecs[3] = '{8'h80, 8'h01, 8'h80, 16'h8001};
      vecs[4] = '{8'hFE, 8'h5A, 8'hA5, 16'hA55A};
      for (int i = 0; i < 256; i++) known[i] = 1'b0;

      rst_n      = 1'b0;
      load_start = 1'b0;
      load_base  = '0;
      load_count = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      lut_addr   = '0;
      #3;
      check("rst_byte_ready", 32'(byte_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic two-entry load.
      run_session(8'h10, 2, '{8'h34, 8'h12, 8'h78, 8'h56}, 1'b0, 1'b0);
      read_lut(8'h10, v); check("basic_0x10", 32'(v), 32'h1234);
      read_lut(8'h11, v); check("basic_0x11", 32'(v), 32'h5678);

      // Address wrap 0xFF -> 0x00.
      run_session(8'hFF, 2, '{8'h01, 8'h00, 8'h02, 8'h00}, 1'b0, 1'b0);
      read_lut(8'hFF, v); check("wrap_0xff", 32'(v), 32'h0001);
      read_lut(8'h00, v); check("wrap_0x00", 32'(v), 32'h0002);

      // Table of single-entry loads.
      for (int i = 0; i < 5; i++) begin
         run_session(vecs[i].base, 1, '{vecs[i].b0, vecs[i].b1}, 1'b0, 1'b0);
         read_lut(vecs[i].base, v);
         check($sformatf("vec%0d_word", i), 32'(v), 32'(vecs[i].exp_word));
      end

`ifndef LUT_WRITER_CHECKSUM_EN
      // Cycle-exact write timing: 0x20 holds 0xABCD, overwrite with 0x2211.
      a0 = acc_count;
      d0 = done_count;
      lut_addr = 8'h20;
      start(8'h20, 9'd1);
      byte_valid = 1'b1;
      byte_data  = 8'h11;
      @(negedge clk);
      check("t1_ready", 32'(byte_ready), 1);
      check("t1_busy", 32'(busy), 1);
      @(posedge clk); #1;
      byte_data = 8'h22;
      @(negedge clk);
      check("t2_ready", 32'(byte_ready), 1);
      @(posedge clk); #1;
      byte_valid = 1'b0;
      @(negedge clk);
      check("t3_write_ready", 32'(byte_ready), 0);
      check("t3_write_old_value", 32'(lut_out), 32'hABCD);
      check("t3_write_done", 32'(done), 0);
      @(negedge clk);
      check("t4_new_value", 32'(lut_out), 32'h2211);
      check("t4_done", 32'(done), 1);
      check("t4_busy", 32'(busy), 1);
      @(negedge clk);
      check("t5_done_low", 32'(done), 0);
      check("t5_busy_low", 32'(busy), 0);
      @(posedge clk); #1;
      check("timing_accepted", 32'(acc_count - a0), 2);
      check("timing_done_pulses", 32'(done_count - d0), 1);
      ref_mem[8'h20] = 16'h2211;
`endif

      // Oversize count: error, done, no byte accepted even with valid held.
      a0 = acc_count;
      d0 = done_count;
      start(8'h50, 9'd300);
      byte_valid = 1'b1;
      byte_data  = 8'h77;
      wait_idle();
      byte_valid = 1'b0;
      check("over_err", 32'(err), 1);
      check("over_accepted", 32'(acc_count - a0), 0);
      check("over_done_pulses", 32'(done_count - d0), 1);
      repeat (3) @(posedge clk);
      #1;
      check("over_err_sticky", 32'(err), 1);
      run_session(8'h31, 1, '{8'hEF, 8'hBE}, 1'b0, 1'b0);
      read_lut(8'h31, v); check("reload_0x31", 32'(v), 32'hBEEF);

      // Reset after 3 of 4 bytes: first entry kept, second address untouched.
      start(8'h30, 9'd2);
      send_stream('{8'hAA, 8'h55, 8'hC3}, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_ready", 32'(byte_ready), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_done", 32'(done), 0);
      check("abort_err", 32'(err), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("abort_idle", 32'(busy), 0);
      ref_mem[8'h30] = 16'h55AA;
      known[8'h30]   = 1'b1;
      read_lut(8'h30, v); check("abort_first_kept", 32'(v), 32'h55AA);
      read_lut(8'h31, v); check("abort_second_unchanged", 32'(v), 32'hBEEF);

      // Random sessions with random valid gaps and ignored load_start pulses.
      for (int s = 0; s < 6; s++) begin
         logic [7:0] base;
         int         count;
         byte_q_t    data;
         base  = 8'($urandom);
         count = $urandom_range(1, 6);
         data  = {};
         for (int k = 0; k < 2 * count; k++) data.push_back(8'($urandom));
         d0 = done_count;
         run_session(base, count, data, 1'b1, 1'b1);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("rand%0d_no_restart", s), 32'(busy), 0);
         check($sformatf("rand%0d_single_done", s), 32'(done_count - d0), 1);
         for (int i = 0; i < count; i++) begin
            read_lut(8'(base + 8'(i)), v);
            check($sformatf("rand%0d_entry%0d", s, i), 32'(v), 32'(ref_mem[8'(base + 8'(i))]));
         end
      end

`ifdef LUT_WRITER_CHECKSUM_EN
      // Correct checksum 0x1234 ^ 0x5678 = 0x444C, then a wrong one.
      d0 = done_count;
      start(8'h60, 9'd2);
      send_stream('{8'h34, 8'h12, 8'h78, 8'h56, 8'h4C, 8'h44}, 1'b0);
      wait_idle();
      check("csum_good_err", 32'(err), 0);
      check("csum_good_done", 32'(done_count - d0), 1);
      d0 = done_count;
      start(8'h70, 9'd2);
      send_stream('{8'h34, 8'h12, 8'h78, 8'h56, 8'h00, 8'h00}, 1'b0);
      wait_idle();
      check("csum_bad_err", 32'(err), 1);
      check("csum_bad_done", 32'(done_count - d0), 1);
      read_lut(8'h70, v); check("csum_bad_kept0", 32'(v), 32'h1234);
      read_lut(8'h71, v); check("csum_bad_kept1", 32'(v), 32'h5678);
      ref_mem[8'h60] = 16'h1234; known[8'h60] = 1'b1;
      ref_mem[8'h61] = 16'h5678; known[8'h61] = 1'b1;
      ref_mem[8'h70] = 16'h1234; known[8'h70] = 1'b1;
      ref_mem[8'h71] = 16'h5678; known[8'h71] = 1'b1;
`endif

      // Whole-table sweep of every address the model has written.
      for (int a = 0; a < 256; a++) begin
         if (known[a]) begin
            read_lut(8'(a), v);
            check($sformatf("sweep_%02h", a), 32'(v), 32'(ref_mem[a]));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
